// File: rtl/fetch_cache.sv
// -----------------------------------------------------------------------------
// fetch_cache
//
// Direct-mapped, read-only instruction cache sitting between the core's fetch
// stage and the instruction memory. One 32-bit word per line. Hits are answered
// one cycle after the request edge; misses refill the line over a req/ack
// handshake and are answered from a RESPOND state.
//
// Ports:
//   clk         single clock, rising edge
//   rst         asynchronous, active-low reset
//   clk_en      fetch request strobe (sampled in IDLE only)
//   read_addr   word address of the requested instruction
//   read_data   instruction word, valid while data_ready=1, held otherwise
//   data_ready  one-cycle pulse per completed fetch
//   flush       invalidate every line on the edge it is sampled
//   mem_req     refill request, held until mem_ack
//   mem_addr    refill word address, stable while mem_req=1
//   mem_data    refill word, valid with mem_ack
//   mem_ack     refill completion strobe (ignored unless refilling)
//   miss_count  misses since reset, wraps at 16 bits
// -----------------------------------------------------------------------------
module fetch_cache #(
    parameter int ADDR_W  = 6,
    parameter int INDEX_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic [ADDR_W-1:0] read_addr,
    output logic [31:0]       read_data,
    output logic              data_ready,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_data,
    input  logic              mem_ack,
    output logic [15:0]       miss_count
);

    localparam int TAG_W = ADDR_W - INDEX_W;
    localparam int LINES = 1 << INDEX_W;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        RESPOND
    } state_t;

    state_t              state_q, state_d;
    logic [LINES-1:0]    valid_q, valid_d;
    logic [31:0]         read_data_q, read_data_d;
    logic                data_ready_q, data_ready_d;
    logic                mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [15:0]         miss_count_q, miss_count_d;
    // Remembers a flush seen earlier in the current refill so the arriving
    // word is returned to the core but not marked valid.
    logic                flushed_q, flushed_d;

    // Tag and data storage carry no reset; valid bits alone gate their use.
    logic [TAG_W-1:0]    tag_arr  [LINES];
    logic [31:0]         data_arr [LINES];

    logic [INDEX_W-1:0]  req_idx;
    logic [TAG_W-1:0]    req_tag;
    logic [INDEX_W-1:0]  fill_idx;
    logic [TAG_W-1:0]    fill_tag;
    logic                hit;
    logic                fill_we;

    assign req_idx  = read_addr[INDEX_W-1:0];
    assign req_tag  = read_addr[ADDR_W-1:INDEX_W];
    // The latched refill address doubles as the fill index/tag source.
    assign fill_idx = mem_addr_q[INDEX_W-1:0];
    assign fill_tag = mem_addr_q[ADDR_W-1:INDEX_W];

    // A flush sampled with the request forces the miss path.
    assign hit     = valid_q[req_idx] && (tag_arr[req_idx] == req_tag) && !flush;
    assign fill_we = (state_q == REFILL) && mem_ack;

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        read_data_d  = read_data_q;
        data_ready_d = 1'b0;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        miss_count_d = miss_count_q;
        flushed_d    = flushed_q;

        case (state_q)
            IDLE: begin
                if (clk_en) begin
                    if (hit) begin
                        read_data_d  = data_arr[req_idx];
                        data_ready_d = 1'b1;
                    end else begin
                        mem_addr_d   = read_addr;
                        mem_req_d    = 1'b1;
                        miss_count_d = miss_count_q + 16'd1;
                        flushed_d    = 1'b0;
                        state_d      = REFILL;
                    end
                end
            end
            REFILL: begin
                if (flush) begin
                    flushed_d = 1'b1;
                end
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    if (!flushed_q) begin
                        valid_d[fill_idx] = 1'b1;
                    end
                    state_d = RESPOND;
                end
            end
            RESPOND: begin
                // The refilled word was written into the array on the ack edge.
                read_data_d  = data_arr[fill_idx];
                data_ready_d = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase

        // Flush overrides any fill on the same edge.
        if (flush) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            read_data_q  <= '0;
            data_ready_q <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            miss_count_q <= '0;
            flushed_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            read_data_q  <= read_data_d;
            data_ready_q <= data_ready_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            miss_count_q <= miss_count_d;
            flushed_q    <= flushed_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_arr[fill_idx]  <= fill_tag;
            data_arr[fill_idx] <= mem_data;
        end
    end

    assign read_data  = read_data_q;
    assign data_ready = data_ready_q;
    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign miss_count = miss_count_q;

endmodule

// File: tb/tb_fetch_cache.sv
// -----------------------------------------------------------------------------
// tb_fetch_cache
//
// Scoreboard bench for fetch_cache. Each fetch pushes its expected word into a
// queue; a monitor on the falling edge pops and compares whenever data_ready is
// high. Control outputs are checked directly from the stimulus thread.
// -----------------------------------------------------------------------------
module tb_fetch_cache;

    localparam int ADDR_W  = 6;
    localparam int INDEX_W = 3;

    logic              clk;
    logic              rst;
    logic              clk_en;
    logic [ADDR_W-1:0] read_addr;
    logic [31:0]       read_data;
    logic              data_ready;
    logic              flush;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_data;
    logic              mem_ack;
    logic [15:0]       miss_count;

    int total = 0;
    int bad   = 0;
    logic [31:0] sb [$];

    fetch_cache #(
        .ADDR_W (ADDR_W),
        .INDEX_W(INDEX_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clk_en    (clk_en),
        .read_addr (read_addr),
        .read_data (read_data),
        .data_ready(data_ready),
        .flush     (flush),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_ack   (mem_ack),
        .miss_count(miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Monitor: every data_ready pulse must match the oldest pending fetch.
    always @(negedge clk) begin
        if (data_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ready got=%h want=no_response", read_data);
            end else begin
                chk("read_data", read_data, sb.pop_front());
            end
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic issue(input logic [ADDR_W-1:0] a);
        clk_en    = 1'b1;
        read_addr = a;
        @(posedge clk);
        #1;
        clk_en    = 1'b0;
    endtask

    task automatic do_hit(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        sb.push_back(d);
        issue(a);
        chk("hit_no_req", {31'd0, mem_req}, 32'd0);
    endtask

    task automatic do_miss(input logic [ADDR_W-1:0] a, input logic [31:0] d,
                           input int delay, input logic fl);
        sb.push_back(d);
        issue(a);
        chk("miss_req", {31'd0, mem_req}, 32'd1);
        chk("miss_addr", {26'd0, mem_addr}, {26'd0, a});
        repeat (delay) begin
            @(posedge clk);
            #1;
        end
        mem_ack  = 1'b1;
        mem_data = d;
        flush    = fl;
        @(posedge clk);
        #1;
        mem_ack  = 1'b0;
        mem_data = '0;
        flush    = 1'b0;
        chk("req_drop", {31'd0, mem_req}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b0;
        clk_en    = 1'b0;
        read_addr = '0;
        flush     = 1'b0;
        mem_data  = '0;
        mem_ack   = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, data_ready}, 32'd0);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_addr", {26'd0, mem_addr}, 32'd0);
        chk("rst_data", read_data, 32'd0);
        chk("rst_count", {16'd0, miss_count}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // First miss, ack two cycles after the request.
        do_miss(6'h05, 32'hDEADBEEF, 2, 1'b0);
        chk("count_1", {16'd0, miss_count}, 32'd1);

        // Back-to-back hits.
        do_hit(6'h05, 32'hDEADBEEF);
        do_hit(6'h05, 32'hDEADBEEF);
        do_hit(6'h05, 32'hDEADBEEF);
        chk("count_hits", {16'd0, miss_count}, 32'd1);

        // Conflict on index 5 evicts 0x05.
        do_miss(6'h0D, 32'h11110D0D, 0, 1'b0);
        do_miss(6'h05, 32'h22220505, 1, 1'b0);
        chk("count_3", {16'd0, miss_count}, 32'd3);
        do_hit(6'h05, 32'h22220505);
        do_hit(6'h0D - 6'h08, 32'h22220505);

        // Flush on the ack edge: data returned, line stays invalid.
        do_miss(6'h12, 32'h12121212, 1, 1'b1);
        do_miss(6'h12, 32'h34343434, 0, 1'b0);
        chk("count_5", {16'd0, miss_count}, 32'd5);
        do_hit(6'h12, 32'h34343434);

        // Flush earlier in a refill also leaves the line invalid.
        sb.push_back(32'h2A2A2A2A);
        issue(6'h2A);
        chk("fl_req", {31'd0, mem_req}, 32'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        mem_ack  = 1'b1;
        mem_data = 32'h2A2A2A2A;
        @(posedge clk);
        #1;
        mem_ack  = 1'b0;
        mem_data = '0;
        @(posedge clk);
        #1;
        do_miss(6'h2A, 32'h2B2B2B2B, 0, 1'b0);
        chk("count_7", {16'd0, miss_count}, 32'd7);

        // Async reset while refilling.
        do_miss(6'h05, 32'h33330505, 0, 1'b0);
        do_hit(6'h05, 32'h33330505);
        issue(6'h1A);
        chk("pre_rst_req", {31'd0, mem_req}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_req", {31'd0, mem_req}, 32'd0);
        chk("async_count", {16'd0, miss_count}, 32'd0);
        chk("async_addr", {26'd0, mem_addr}, 32'd0);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        mem_ack  = 1'b1;
        mem_data = 32'hBADBAD00;
        @(posedge clk);
        #1;
        mem_ack  = 1'b0;
        mem_data = '0;
        chk("late_ack_req", {31'd0, mem_req}, 32'd0);
        @(posedge clk);
        #1;
        chk("late_ack_ready", {31'd0, data_ready}, 32'd0);
        do_miss(6'h05, 32'h55550505, 0, 1'b0);
        chk("count_after_rst", {16'd0, miss_count}, 32'd1);

        // Counter wrap: preset near the top, then alternate conflicting misses.
        force dut.miss_count_q = 16'hFFFD;
        @(posedge clk);
        #1;
        release dut.miss_count_q;
        do_miss(6'h00, 32'hA0A0A0A0, 0, 1'b0);
        chk("count_fffe", {16'd0, miss_count}, 32'h0000FFFE);
        do_miss(6'h08, 32'hA8A8A8A8, 0, 1'b0);
        chk("count_ffff", {16'd0, miss_count}, 32'h0000FFFF);
        do_miss(6'h00, 32'hB0B0B0B0, 0, 1'b0);
        chk("count_wrap", {16'd0, miss_count}, 32'd0);
        do_miss(6'h08, 32'hB8B8B8B8, 0, 1'b0);
        chk("count_after_wrap", {16'd0, miss_count}, 32'd1);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Stimulus has no unbounded waits; this only guards against a stuck clock.
    initial begin
        #200000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1);
    end

endmodule

// File: doc/fetch_cache.md
# fetch_cache

Direct-mapped, read-only instruction cache that answers the core's fetch port (`read_addr` in, `read_data`/`data_ready` out) and refills missing words from backing instruction memory over a req/ack handshake. It sits between the core's fetch stage and the instruction ROM/RAM. It is the responder end of the fetch interface the core already drives.

## Interface
Parameters:
- ADDR_W, 6, word-address width of fetch and memory ports
- INDEX_W, 3, index bits; 2^INDEX_W lines, one 32-bit word per line
- Tag width is ADDR_W-INDEX_W (derived, not a parameter)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- clk_en  in  1  request strobe; fetch address sampled when high and ready
- read_addr  in  ADDR_W  word address of instruction
- read_data  out  32  instruction word; valid when data_ready=1
- data_ready  out  1  one-cycle pulse per completed fetch
- flush  in  1  invalidate all lines
- mem_req  out  1  refill request, held until ack
- mem_addr  out  ADDR_W  refill word address, stable while mem_req=1
- mem_data  in  32  refill word, valid with mem_ack
- mem_ack  in  1  refill completion, one cycle
- miss_count  out  16  number of misses since reset, wraps 0xFFFF->0

## Operation
- Storage: per line valid bit, tag, 32-bit word. index=read_addr[INDEX_W-1:0], tag=read_addr[ADDR_W-1:INDEX_W].
- FSM states: IDLE, REFILL, RESPOND.
- IDLE, clk_en=1: hit (valid & tag match & flush=0) -> read_data=line word, data_ready=1 next cycle, stay IDLE. Miss -> latch address, mem_addr=read_addr, mem_req=1, miss_count+1, go REFILL, data_ready=0.
- IDLE, clk_en=0: no request; data_ready=0 next cycle.
- REFILL: mem_req held; read_addr/clk_en ignored. On mem_ack=1: write word, tag, valid=1 to latched index; read_data=mem_data; mem_req=0; go RESPOND.
- RESPOND: data_ready=1 for exactly this cycle; return to IDLE. No new request accepted in RESPOND.
- flush: clears all valid bits on the edge it is sampled. flush with IDLE request -> treated as miss. flush during REFILL -> refill completes and data is returned, but the line is left invalid (flush wins over fill, incl. same-cycle flush+mem_ack).
- mem_ack while mem_req=0 is ignored.
- read_data holds its last value when data_ready=0.

## Timing
- Reset (rst=0, async): state IDLE, all valid=0, read_data=0, data_ready=0, mem_req=0, mem_addr=0, miss_count=0. Tag/data arrays need not be reset.
- Reset mid-REFILL: mem_req drops immediately (async); no response is issued; a later mem_ack is ignored.
- Hit latency: request sampled at edge N, data_ready=1 during cycle after edge N; back-to-back hits sustain 1 fetch/cycle.
- Miss: request at edge N; mem_req=1 after edge N; mem_ack sampled at edge M (M>N); data_ready=1 during the cycle after edge M+1 (RESPOND). The next request is accepted at the edge ending RESPOND+1 (IDLE). Minimum miss latency is 3 cycles with mem_ack at the first opportunity.
- mem_addr and mem_req change only at clock edges (or on async reset).
- miss_count increments on the IDLE->REFILL edge only.

## Test plan
- Reset then fetch addr 0x05, mem_ack 2 cycles after mem_req with 0xDEADBEEF -> mem_addr=0x05, data_ready pulse, read_data=0xDEADBEEF, miss_count=1.
- Refetch 0x05 on consecutive cycles -> data_ready=1 each cycle after edge, no mem_req, miss_count stays 1.
- Fetch 0x0D (same index 5, different tag) -> miss and refill; then 0x05 -> miss again (evicted); miss_count=3.
- flush asserted same cycle as mem_ack for 0x12 -> data returned once, subsequent fetch of 0x12 misses.
- Drop rst while mem_req=1 -> mem_req=0 immediately, no data_ready, late mem_ack ignored, next 0x05 fetch misses.
- 65536 forced misses (alternate 0x00/0x08) -> miss_count wraps to 0x0000.
